// File: rtl/mips_pkg.sv
// Shared types for the MIPS multiply/divide unit: op codes, FSM states, counter width helper.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_DIV   = 2'b01,
    MD_MULTU = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIXUP
  } muldiv_state_t;

  function automatic int unsigned md_cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mult/div engine: shift-add for multiply, restoring subtract for divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_bit_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    // Remainder after a successful subtract is below the divisor, so W bits suffice.
    diff    = rem_sh[WIDTH-1:0] - opnd_i;
    q_bit_o = 1'b0;
    acc_o   = {sum, acc_i[WIDTH-1:1]};
    if (div_i) begin
      q_bit_o = (rem_sh >= {1'b0, opnd_i});
      acc_o   = {(q_bit_o ? diff : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit owning HI/LO; one bit per clock on latched magnitudes.
// Optional MULDIV_UNSIGNED_EN enables MULTU/DIVU via op[1]; otherwise op[1] is ignored.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = md_cnt_w(WIDTH);

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dzo_q, dzo_d;

  muldiv_op_t       op_e;
  logic             is_div, is_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, quot, rem;
  logic [2*WIDTH-1:0] prod, step_acc;
  logic             step_q;

`ifdef MULDIV_UNSIGNED_EN
  assign op_e = muldiv_op_t'(op);
`else
  logic op_hi_unused;
  assign op_hi_unused = op[1];
  assign op_e = op[0] ? MD_DIV : MD_MULT;
`endif

  assign is_div = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign is_sgn = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign a_neg  = is_sgn & rs_val[WIDTH-1];
  assign b_neg  = is_sgn & rt_val[WIDTH-1];
  // Negating MIN yields 2^(W-1), which is exactly representable as an unsigned magnitude.
  assign a_mag  = a_neg ? -rs_val : rs_val;
  assign b_mag  = b_neg ? -rt_val : rt_val;

  assign quot = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign prod = qneg_q ? -acc_q : acc_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .div_i   (div_q),
    .acc_o   (step_acc),
    .q_bit_o (step_q)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dzo_d   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          div_d   = is_div;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          opnd_d  = is_div ? b_mag : a_mag;
          acc_d   = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
          count_d = CNT_W'(WIDTH - 1);
          dz_d    = is_div && (rt_val == '0);
          state_d = dz_d ? MD_FIXUP : MD_CALC;
        end
      end
      MD_CALC: begin
        acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
        if (count_q == '0) begin
          state_d = MD_FIXUP;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      MD_FIXUP: begin
        state_d = MD_IDLE;
        done_d  = 1'b1;
        dzo_d   = dz_q;
        if (!dz_q) begin
          if (div_q) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dzo_q   <= dzo_d;
    end
  end

  assign busy     = (state_q != MD_IDLE);
  assign done     = done_q;
  assign div_zero = dzo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv (WIDTH=32): arithmetic reference model plus directed literal vectors.
module tb_mips_muldiv;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int vectors = 0;
  int errors  = 0;

  mips_muldiv #(.WIDTH(32)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Returns {div_zero, hi, lo} computed with plain 64-bit arithmetic.
  function automatic logic [64:0] model_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    longint sa, sb, q, r, p;
`ifdef MULDIV_UNSIGNED_EN
    sgn = !o[1];
`else
    sgn = 1'b1;
`endif
    sa = sgn ? longint'(signed'(a)) : longint'(a);
    sb = sgn ? longint'(signed'(b)) : longint'(b);
    if (o[0]) begin
      if (b == 32'd0) return {1'b1, 64'd0};
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    p = sa * sb;
    return {1'b0, p[63:0]};
  endfunction

  logic [31:0] m_hi, m_lo;
  logic        m_done, m_dz;
  logic [64:0] m_res;
  int          m_left;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dz <= 1'b0; m_left <= 0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_res  <= model_calc(op, rs_val, rt_val);
          m_left <= (op[0] && rt_val == 32'd0) ? 1 : 33;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_dz   <= m_res[64];
          if (!m_res[64]) begin
            m_hi <= m_res[63:32];
            m_lo <= m_res[31:0];
          end
        end
      end
    end
  end

  always @(negedge Clk) begin
    chk("busy", 64'(busy), 64'(m_left != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("div_zero", 64'(div_zero), 64'(m_dz));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
  endtask

  task automatic wait_done(input string nm, input int lat, input logic [31:0] eh,
                           input logic [31:0] el, input logic edz, input int repulse);
    int  n = 0;
    bit  seen = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge Clk);
      n++;
      start  = 1'b0;
      op     = 2'($urandom);
      rs_val = $urandom;
      rt_val = $urandom;
      if (done) seen = 1'b1;
      else begin
        chk({nm, "_busy"}, 64'(busy), 64'd1);
        if (n == repulse) start = 1'b1;
      end
    end
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_dz"}, 64'(div_zero), 64'(edz));
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
    chk({nm, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    start_op(2'b00, 32'd7, 32'hFFFFFFFD);
    wait_done("mult_7_m3", 34, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0);
    start_op(2'b01, 32'hFFFFFFF9, 32'd2);
    wait_done("div_m7_2", 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    start_op(2'b01, 32'd7, 32'hFFFFFFFE);
    wait_done("div_7_m2", 34, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
    start_op(2'b01, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_min_m1", 34, 32'h00000000, 32'h80000000, 1'b0, 0);
    start_op(2'b01, 32'h56781234, 32'h00010000);
    wait_done("preload", 34, 32'h00001234, 32'h00005678, 1'b0, 0);
    start_op(2'b01, 32'd5, 32'd0);
    wait_done("div_zero", 2, 32'h00001234, 32'h00005678, 1'b1, 0);
    start_op(2'b00, 32'h80000000, 32'h80000000);
    wait_done("mult_min_min", 34, 32'h40000000, 32'h00000000, 1'b0, 0);
`ifdef MULDIV_UNSIGNED_EN
    start_op(2'b11, 32'hFFFFFFFF, 32'd2);
    wait_done("op11_ff_2", 34, 32'h00000001, 32'h7FFFFFFF, 1'b0, 0);
    start_op(2'b10, 32'hFFFFFFFF, 32'd2);
    wait_done("op10_ff_2", 34, 32'h00000001, 32'hFFFFFFFE, 1'b0, 0);
`else
    start_op(2'b11, 32'hFFFFFFFF, 32'd2);
    wait_done("op11_ff_2", 34, 32'hFFFFFFFF, 32'h00000000, 1'b0, 0);
    start_op(2'b10, 32'hFFFFFFFF, 32'd2);
    wait_done("op10_ff_2", 34, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0);
`endif
    start_op(2'b00, 32'd5, 32'd6);
    wait_done("repulse", 34, 32'h00000000, 32'h0000001E, 1'b0, 10);

    // Abort an operation with reset partway through CALC.
    start_op(2'b00, 32'd9, 32'd9);
    repeat (10) begin
      @(negedge Clk);
      start = 1'b0;
    end
    Reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    start_op(2'b00, 32'd3, 32'd4);
    wait_done("mult_3_4", 34, 32'h00000000, 32'h0000000C, 1'b0, 0);

    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
